// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types, lamp encodings and phase helpers for the two-way intersection controller.
// Phase durations are passed in so that each instance can carry its own timing parameters.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_A,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_B,
    FLASH
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic state_e next_phase(input state_e s);
    state_e n;
    case (s)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_A;
      ALLRED_A:  n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALLRED_B;
      ALLRED_B:  n = NS_GREEN;
      default:   n = ALLRED_B;
    endcase
    return n;
  endfunction

  // FLASH has no countdown, so it maps to zero and the display reads blank time.
  function automatic int unsigned phase_duration(input state_e s,
                                                 input int unsigned green_t,
                                                 input int unsigned yellow_t,
                                                 input int unsigned allred_t);
    int unsigned d;
    case (s)
      NS_GREEN, EW_GREEN:   d = green_t;
      NS_YELLOW, EW_YELLOW: d = yellow_t;
      ALLRED_A, ALLRED_B:   d = allred_t;
      default:              d = 0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the tick source / request inputs and the lamp and countdown drivers.
// The controller sits on the slave side; whoever drives tick and requests uses master.
interface traffic_light_ctrl_if #(
  parameter int CNT_W = 8
);

  logic             tick;
  logic             ped_req;
  logic             night_mode;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic [CNT_W-1:0] remain;
  logic             ped_pending;

  modport master (
    output tick, ped_req, night_mode,
    input  ns_light, ew_light, remain, ped_pending
  );

  modport slave (
    input  tick, ped_req, night_mode,
    output ns_light, ew_light, remain, ped_pending
  );

endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Loadable down-counter holding the ticks left in the current phase.
// Load beats tick, and tick beats the pedestrian shortening request.
module traffic_light_ctrl_phase_timer #(
  parameter int CNT_W     = 8,
  parameter int PED_MIN   = 2,
  parameter int RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  input  logic             shorten_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] PED_VAL = CNT_W'(PED_MIN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Zero is held rather than wrapped so that the flash-mode blank value stays put across ticks.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end else if (shorten_i && (cnt_q > PED_VAL)) begin
      cnt_d = PED_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Phase sequencer for a two-way intersection with pedestrian shortening and night flash.
// Lamps are decoded from the next state so they change on the same edge as the phase.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 9,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_MIN  = 2,
  parameter int CNT_W    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_light_ctrl_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic             flash_q;
  logic             flash_d;
  logic             ped_q;
  logic             ped_d;
  logic [2:0]       ns_q;
  logic [2:0]       ns_d;
  logic [2:0]       ew_q;
  logic [2:0]       ew_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             shorten;
  logic [CNT_W-1:0] remain;
  logic             last;

  traffic_light_ctrl_phase_timer #(
    .CNT_W    (CNT_W),
    .PED_MIN  (PED_MIN),
    .RESET_VAL(ALLRED_T)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .load_val_i(load_val),
    .tick_i    (bus.tick),
    .shorten_i (shorten),
    .cnt_o     (remain),
    .last_o    (last)
  );

  // Night mode overrides everything; otherwise a tick on the last count advances the phase.
  always_comb begin
    state_d  = state_q;
    flash_d  = flash_q;
    load     = 1'b0;
    load_val = '0;
    if (state_q != FLASH) begin
      if (bus.night_mode) begin
        state_d = FLASH;
        flash_d = 1'b0;
        load    = 1'b1;
      end else if (bus.tick && last) begin
        state_d  = next_phase(state_q);
        load     = 1'b1;
        load_val = CNT_W'(phase_duration(state_d, GREEN_T, YELLOW_T, ALLRED_T));
      end
    end else if (!bus.night_mode) begin
      state_d  = ALLRED_B;
      flash_d  = 1'b0;
      load     = 1'b1;
      load_val = CNT_W'(ALLRED_T);
    end else if (bus.tick) begin
      flash_d = ~flash_q;
    end
  end

  assign shorten = ped_q && !bus.tick && ((state_q == NS_GREEN) || (state_q == EW_GREEN));

  // A fresh request on the clearing edge survives so it can serve the next green.
  always_comb begin
    ped_d = ped_q;
    if ((state_d != state_q) && ((state_d == ALLRED_A) || (state_d == ALLRED_B))) begin
      ped_d = 1'b0;
    end
    if (bus.ped_req) begin
      ped_d = 1'b1;
    end
  end

  always_comb begin
    ns_d = LAMP_RED;
    ew_d = LAMP_RED;
    case (state_d)
      NS_GREEN:  ns_d = LAMP_GRN;
      NS_YELLOW: ns_d = LAMP_YEL;
      EW_GREEN:  ew_d = LAMP_GRN;
      EW_YELLOW: ew_d = LAMP_YEL;
      FLASH: begin
        ns_d = flash_d ? LAMP_YEL : LAMP_OFF;
        ew_d = flash_d ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ALLRED_B;
      flash_q <= 1'b0;
      ped_q   <= 1'b0;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
    end else begin
      state_q <= state_d;
      flash_q <= flash_d;
      ped_q   <= ped_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign bus.ns_light    = ns_q;
  assign bus.ew_light    = ew_q;
  assign bus.remain      = remain;
  assign bus.ped_pending = ped_q;

  // Conflicting right-of-way outside flash mode means the sequencer is broken.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != FLASH) |-> !((ns_q[1:0] != 2'b00) && (ew_q[1:0] != 2'b00)));

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: full cycle, pedestrian shortening, night flash and reset.
// Ticks arrive every 4 clocks; outputs are sampled 1 ns after the rising edge.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;

  localparam logic [2:0] NS_TAB [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  localparam logic [2:0] EW_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  localparam int         DUR_TAB[6] = '{9, 3, 1, 9, 3, 1};

  traffic_light_ctrl_if #(.CNT_W(8)) tif ();

  traffic_light_ctrl #(
    .GREEN_T (9),
    .YELLOW_T(3),
    .ALLRED_T(1),
    .PED_MIN (2),
    .CNT_W   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (tif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Three idle clocks then a one-clock tick; the caller samples right after the tick edge.
  task automatic pulse_tick();
    repeat (3) step();
    tif.tick = 1'b1;
    step();
    tif.tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checkCount++; if (tif.remain !== 8'd1) $display("[TB] FAIL reset_remain: got %0d want 1", tif.remain); else passCount++;
    checkCount++; if (tif.ns_light !== 3'b100) $display("[TB] FAIL reset_ns: got %b want 100", tif.ns_light); else passCount++;
    checkCount++; if (tif.ew_light !== 3'b100) $display("[TB] FAIL reset_ew: got %b want 100", tif.ew_light); else passCount++;
    checkCount++; if (tif.ped_pending !== 1'b0) $display("[TB] FAIL reset_ped: got %b want 0", tif.ped_pending); else passCount++;
    rst_n = 1'b1;
    step();
    checkCount++; if (tif.remain !== 8'd1) $display("[TB] FAIL idle_after_reset: got %0d want 1", tif.remain); else passCount++;
  endtask

  // Walks 26 ticks from ALLRED_B through a full cycle using the phase tables.
  task automatic test_full_cycle();
    int idx = 5;
    int rem = 1;
    for (int t = 1; t <= 26; t++) begin
      pulse_tick();
      if (rem == 1) begin
        idx = (idx + 1) % 6;
        rem = DUR_TAB[idx];
      end else begin
        rem--;
      end
      checkCount++; if (tif.remain !== 8'(rem)) $display("[TB] FAIL cycle_remain t=%0d: got %0d want %0d", t, tif.remain, rem); else passCount++;
      checkCount++; if (tif.ns_light !== NS_TAB[idx]) $display("[TB] FAIL cycle_ns t=%0d: got %b want %b", t, tif.ns_light, NS_TAB[idx]); else passCount++;
      checkCount++; if (tif.ew_light !== EW_TAB[idx]) $display("[TB] FAIL cycle_ew t=%0d: got %b want %b", t, tif.ew_light, EW_TAB[idx]); else passCount++;
    end
  endtask

  task automatic test_ped_shorten();
    pulse_tick();
    repeat (2) pulse_tick();
    checkCount++; if (tif.remain !== 8'd7) $display("[TB] FAIL ped_pre: got %0d want 7", tif.remain); else passCount++;
    tif.ped_req = 1'b1;
    step();
    tif.ped_req = 1'b0;
    checkCount++; if (tif.ped_pending !== 1'b1) $display("[TB] FAIL ped_set: got %b want 1", tif.ped_pending); else passCount++;
    checkCount++; if (tif.remain !== 8'd7) $display("[TB] FAIL ped_not_yet: got %0d want 7", tif.remain); else passCount++;
    step();
    checkCount++; if (tif.remain !== 8'd2) $display("[TB] FAIL ped_short: got %0d want 2", tif.remain); else passCount++;
    pulse_tick();
    checkCount++; if (tif.remain !== 8'd1) $display("[TB] FAIL ped_dec: got %0d want 1", tif.remain); else passCount++;
    pulse_tick();
    checkCount++; if (tif.ns_light !== 3'b010) $display("[TB] FAIL ped_yellow: got %b want 010", tif.ns_light); else passCount++;
    checkCount++; if (tif.remain !== 8'd3) $display("[TB] FAIL ped_yellow_rem: got %0d want 3", tif.remain); else passCount++;
    checkCount++; if (tif.ped_pending !== 1'b1) $display("[TB] FAIL ped_hold: got %b want 1", tif.ped_pending); else passCount++;
    repeat (3) pulse_tick();
    checkCount++; if (tif.ns_light !== 3'b100 || tif.ew_light !== 3'b100) $display("[TB] FAIL ped_allred: got %b/%b want 100/100", tif.ns_light, tif.ew_light); else passCount++;
    checkCount++; if (tif.ped_pending !== 1'b0) $display("[TB] FAIL ped_clear: got %b want 0", tif.ped_pending); else passCount++;
  endtask

  task automatic test_ped_no_shorten();
    pulse_tick();
    checkCount++; if (tif.ew_light !== 3'b001 || tif.remain !== 8'd9) $display("[TB] FAIL ew_green: got %b rem %0d want 001 rem 9", tif.ew_light, tif.remain); else passCount++;
    repeat (7) pulse_tick();
    tif.ped_req = 1'b1;
    step();
    tif.ped_req = 1'b0;
    step();
    checkCount++; if (tif.remain !== 8'd2) $display("[TB] FAIL noshort_rem: got %0d want 2", tif.remain); else passCount++;
    checkCount++; if (tif.ped_pending !== 1'b1) $display("[TB] FAIL noshort_ped: got %b want 1", tif.ped_pending); else passCount++;
    pulse_tick();
    pulse_tick();
    checkCount++; if (tif.ew_light !== 3'b010 || tif.ped_pending !== 1'b1) $display("[TB] FAIL noshort_yel: got %b ped %b want 010 ped 1", tif.ew_light, tif.ped_pending); else passCount++;
    repeat (3) pulse_tick();
    checkCount++; if (tif.ped_pending !== 1'b0) $display("[TB] FAIL noshort_clear: got %b want 0", tif.ped_pending); else passCount++;
    checkCount++; if (tif.remain !== 8'd1) $display("[TB] FAIL noshort_allred: got %0d want 1", tif.remain); else passCount++;
  endtask

  task automatic test_ped_with_tick();
    repeat (5) pulse_tick();
    checkCount++; if (tif.remain !== 8'd5) $display("[TB] FAIL pt_pre: got %0d want 5", tif.remain); else passCount++;
    tif.ped_req = 1'b1;
    tif.tick    = 1'b1;
    step();
    tif.ped_req = 1'b0;
    tif.tick    = 1'b0;
    checkCount++; if (tif.remain !== 8'd4) $display("[TB] FAIL pt_tick: got %0d want 4", tif.remain); else passCount++;
    step();
    checkCount++; if (tif.remain !== 8'd2) $display("[TB] FAIL pt_short: got %0d want 2", tif.remain); else passCount++;
    repeat (6) pulse_tick();
    checkCount++; if (tif.ew_light !== 3'b001 || tif.remain !== 8'd9) $display("[TB] FAIL pt_ewgreen: got %b rem %0d want 001 rem 9", tif.ew_light, tif.remain); else passCount++;
  endtask

  task automatic test_night();
    tif.night_mode = 1'b1;
    step();
    checkCount++; if (tif.ns_light !== 3'b000 || tif.ew_light !== 3'b000) $display("[TB] FAIL night_entry: got %b/%b want 000/000", tif.ns_light, tif.ew_light); else passCount++;
    checkCount++; if (tif.remain !== 8'd0) $display("[TB] FAIL night_remain: got %0d want 0", tif.remain); else passCount++;
    pulse_tick();
    checkCount++; if (tif.ns_light !== 3'b010 || tif.ew_light !== 3'b010) $display("[TB] FAIL flash_on: got %b/%b want 010/010", tif.ns_light, tif.ew_light); else passCount++;
    checkCount++; if (tif.remain !== 8'd0) $display("[TB] FAIL flash_remain: got %0d want 0", tif.remain); else passCount++;
    pulse_tick();
    checkCount++; if (tif.ns_light !== 3'b000 || tif.ew_light !== 3'b000) $display("[TB] FAIL flash_off: got %b/%b want 000/000", tif.ns_light, tif.ew_light); else passCount++;
    tif.night_mode = 1'b0;
    step();
    checkCount++; if (tif.ns_light !== 3'b100 || tif.ew_light !== 3'b100) $display("[TB] FAIL night_exit: got %b/%b want 100/100", tif.ns_light, tif.ew_light); else passCount++;
    checkCount++; if (tif.remain !== 8'd1) $display("[TB] FAIL night_exit_rem: got %0d want 1", tif.remain); else passCount++;
    pulse_tick();
    checkCount++; if (tif.ns_light !== 3'b001 || tif.remain !== 8'd9) $display("[TB] FAIL night_resume: got %b rem %0d want 001 rem 9", tif.ns_light, tif.remain); else passCount++;
  endtask

  task automatic test_reset_mid();
    repeat (22) pulse_tick();
    checkCount++; if (tif.ew_light !== 3'b010 || tif.remain !== 8'd3) $display("[TB] FAIL mid_ewyel: got %b rem %0d want 010 rem 3", tif.ew_light, tif.remain); else passCount++;
    tif.ped_req = 1'b1;
    step();
    tif.ped_req = 1'b0;
    checkCount++; if (tif.ped_pending !== 1'b1) $display("[TB] FAIL mid_ped: got %b want 1", tif.ped_pending); else passCount++;
    rst_n    = 1'b0;
    tif.tick = 1'b1;
    step();
    rst_n    = 1'b1;
    tif.tick = 1'b0;
    checkCount++; if (tif.remain !== 8'd1) $display("[TB] FAIL mid_rst_rem: got %0d want 1", tif.remain); else passCount++;
    checkCount++; if (tif.ns_light !== 3'b100 || tif.ew_light !== 3'b100) $display("[TB] FAIL mid_rst_lamps: got %b/%b want 100/100", tif.ns_light, tif.ew_light); else passCount++;
    checkCount++; if (tif.ped_pending !== 1'b0) $display("[TB] FAIL mid_rst_ped: got %b want 0", tif.ped_pending); else passCount++;
    pulse_tick();
    checkCount++; if (tif.ns_light !== 3'b001 || tif.remain !== 8'd9) $display("[TB] FAIL mid_resume: got %b rem %0d want 001 rem 9", tif.ns_light, tif.remain); else passCount++;
  endtask

  initial begin
    tif.tick       = 1'b0;
    tif.ped_req    = 1'b0;
    tif.night_mode = 1'b0;
    rst_n          = 1'b0;
    test_reset();
    test_full_cycle();
    test_ped_shorten();
    test_ped_no_shorten();
    test_ped_with_tick();
    test_night();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Sequences a two-way (North-South / East-West) intersection from a one-cycle 1 s tick supplied by the team's 1 s pulse generator.
- Drives one-hot red/yellow/green lamps per direction and a seconds-remaining value for the countdown display.
- Supports a pedestrian request that shortens the current green phase.
- Supports a night mode in which both directions flash yellow.
- Sits between the pulse generator and the lamp/7-segment drivers.

Parameters:
- GREEN_T, 9: green duration in ticks; must be at least 1.
- YELLOW_T, 3: yellow duration in ticks; must be at least 1.
- ALLRED_T, 1: all-red clearance duration in ticks; must be at least 1.
- PED_MIN, 2: remaining green ticks after a pedestrian shortening; must satisfy 1 <= PED_MIN <= GREEN_T.
- CNT_W, 8: width of `remain`; every duration must fit in it.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- tick, in, 1: one-cycle 1 s pulse.
- ped_req, in, 1: pedestrian button, level or pulse.
- night_mode, in, 1: flash-yellow mode enable.
- ns_light, out, 3: NS lamps, {red, yellow, green}, one-hot or all zero.
- ew_light, out, 3: EW lamps, same encoding as ns_light.
- remain, out, CNT_W: ticks left in the current phase.
- ped_pending, out, 1: pedestrian request latched and not yet served.

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - State = ALLRED_B.
  - remain = ALLRED_T.
  - ns_light = ew_light = 3'b100.
  - ped_pending = 0; flash phase = 0.
  - All outputs are registered.
- Cycle order: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN.
- Lamps per state:
  - NS_GREEN: NS=001, EW=100.
  - NS_YELLOW: NS=010, EW=100.
  - ALLRED_A, ALLRED_B: both 100.
  - EW_GREEN: EW=001, NS=100.
  - EW_YELLOW: EW=010, NS=100.
- Timing rules:
  - On entry to a phase, remain is loaded with that phase's duration.
  - Each tick decrements remain by 1.
  - A tick seen while remain==1 instead advances the state and loads the next phase's duration in the same edge.
  - Each phase therefore lasts exactly its duration in ticks; remain never shows 0 outside FLASH.
  - Lamps change on the same edge as the state.
- Pedestrian handling:
  - ped_req=1 sets ped_pending on the next edge, in any state; repeated requests are absorbed.
  - Shortening: in a cycle where the state is NS_GREEN or EW_GREEN, ped_pending=1, tick=0 and remain > PED_MIN, set remain <= PED_MIN.
  - In a tick cycle, the normal decrement takes priority; shortening is evaluated again on the next non-tick cycle.
  - ped_pending clears on the edge entering ALLRED_A or ALLRED_B.
  - If ped_req=1 on that same edge, it wins and ped_pending stays 1.
- Night mode:
  - night_mode=1 at any edge, in any state, enters FLASH next edge.
  - In FLASH: remain=0.
  - In FLASH: ns_light = ew_light = {1'b0, phase, 1'b0}.
  - In FLASH: phase toggles on each tick, starting at 0 on entry.
  - In FLASH: ped_pending is held, not cleared.
  - night_mode=0 while in FLASH -> ALLRED_B with remain=ALLRED_T, both lamps red; normal cycling then resumes.
- Never allowed: green or yellow shown on both directions at once (checked by an assertion in any non-FLASH state).
- rst_n=0 mid-phase or in FLASH: next-edge reset values apply unconditionally and override tick, ped_req and night_mode.

Decomposition:
- Package traffic_pkg:
  - State enum: NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, FLASH.
  - Lamp constants: LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000.
  - Function mapping state to duration.
- Optional sub-module phase_timer: loadable down-counter with load value, load strobe, tick, shorten-to-PED_MIN request, and a last-tick flag.
- The FSM and lamp decode stay in traffic_light_ctrl.
- The 1 s pulse generator is instantiated at the top level, not inside this block.

Test Plan:
- Reset, then drive tick every 4 clocks with default parameters:
  - After 1 tick: NS_GREEN, remain=9.
  - 9 ticks later: NS_YELLOW, remain=3.
  - 3 ticks later: ALLRED_A, remain=1.
  - 1 tick later: EW_GREEN, remain=9.
  - Full cycle is 26 ticks; lamps are correct at each edge.
- ped_req pulse in NS_GREEN at remain=7, no tick pending:
  - ped_pending=1 the next edge; remain=2 the edge after.
  - Yellow after 2 more ticks.
  - ped_pending=0 on entry to ALLRED_A.
- ped_req at remain=2 (not > PED_MIN): no shortening; ped_pending=1 until ALLRED_A.
- ped_req and tick on the same edge at remain=5:
  - That edge gives remain=4.
  - The next non-tick cycle gives remain=2.
- night_mode=1 in EW_GREEN:
  - Next edge: FLASH, lamps 000/000, remain=0.
  - After 1 tick: both 010; after 2 ticks: both 000.
  - night_mode=0: ALLRED_B, both 100, remain=1; then NS_GREEN after 1 tick.
- rst_n=0 for one edge while in EW_YELLOW with tick=1 and ped_pending=1: ALLRED_B, remain=1, both lamps 100, ped_pending=0.
